// File: rtl/cpu_core_ctrl_axil_master.sv
// AXI4-Lite initiator for the CPU core controller slave port.
// One single-beat read or write at a time behind a command/response handshake.
module cpu_core_ctrl_axil_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  // Host command/response interface
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] AddrMask = {{(AW - 2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          write_q, write_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cmd_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Held low during the reset cycle itself.
        cmd_ready = ~m_axi_areset;
        if (cmd_valid) begin
          addr_d  = cmd_addr & AddrMask;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          if (cmd_write) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      StWr: begin
        // AW and W retire independently; leave once neither is outstanding.
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRdAddr: begin
        if (m_axi_arready) begin
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == StWrResp);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == StRdAddr);
  assign m_axi_rready  = (state_q == StRdData);

  assign rsp_valid = (state_q == StRsp);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_cpu_core_ctrl_axil_master.sv
// Bench for cpu_core_ctrl_axil_master: behavioural AXI-Lite slave with programmable
// delays, response scoreboard, and directed latency/ordering/reset scenarios.
module tb_cpu_core_ctrl_axil_master;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  cpu_core_ctrl_axil_master #(
    .C_M_AXI_ADDR_WIDTH(16),
    .C_M_AXI_DATA_WIDTH(32)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (areset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;

  // Slave configuration and bookkeeping
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  int          b_count = 0;
  int          aw_cnt, w_cnt, ar_cnt, r_wait, b_wait;
  bit          aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_done, w_done, r_pend, b_pend;

  // Monitor bookkeeping
  logic [15:0] exp_awaddr = '0, exp_araddr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int          aw_run = 0, w_run = 0, ar_run = 0, aw_len = 0, w_len = 0, ar_len = 0;
  int          rsp_rise = 0, hs_cyc = 0, acc_cyc = 0;
  logic        rsp_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // AXI-Lite slave: decisions made on the falling edge, handshakes land on the next rising edge.
  initial begin
    awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; bresp = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0; b_wait = 0;
    {aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_done, w_done, r_pend, b_pend} = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        {aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_done, w_done, r_pend, b_pend} = '0;
      end else begin
        if (r_hs) begin rvalid = 0; r_pend = 0; end
        if (b_hs) begin bvalid = 0; b_pend = 0; end
        if (ar_hs) begin r_pend = 1; r_wait = r_dly; end
        if (aw_hs) aw_done = 1;
        if (w_hs) w_done = 1;
        if (aw_done && w_done) begin
          b_pend = 1; b_wait = b_dly; aw_done = 0; w_done = 0;
        end
        if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (r_pend && !rvalid) begin
          if (r_wait == 0) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; end
          else r_wait--;
        end
        if (b_pend && !bvalid) begin
          if (b_wait == 0) begin bvalid = 1; bresp = s_bresp; end
          else b_wait--;
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        b_hs  = bvalid && bready;
        if (b_hs) b_count++;
      end
    end
  end

  // Monitor: channel payloads, valid run lengths, response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (areset) begin
        aw_run = 0; w_run = 0; ar_run = 0; rsp_prev = 1'b0;
      end else begin
        if (awvalid) begin
          check("awaddr", {16'h0, awaddr}, {16'h0, exp_awaddr});
          aw_run++;
        end else if (aw_run != 0) begin aw_len = aw_run; aw_run = 0; end
        if (wvalid) begin
          check("wdata", wdata, exp_wdata);
          check("wstrb", {28'h0, wstrb}, {28'h0, exp_wstrb});
          w_run++;
        end else if (w_run != 0) begin w_len = w_run; w_run = 0; end
        if (arvalid) begin
          check("araddr", {16'h0, araddr}, {16'h0, exp_araddr});
          ar_run++;
        end else if (ar_run != 0) begin ar_len = ar_run; ar_run = 0; end
        if (rsp_valid && !rsp_prev) rsp_rise = cyc;
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_spurious", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_write", {31'h0, rsp_write}, {31'h0, e.wr});
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", {30'h0, rsp_resp}, {30'h0, e.resp});
          end
          hs_cyc = cyc;
        end
        rsp_prev = rsp_valid;
      end
    end
  end

  task automatic set_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp_rd,
                         input logic [1:0] exp_resp);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    if (wr) begin
      exp_awaddr = addr & 16'hFFFC;
      exp_wdata  = wd;
      exp_wstrb  = ws;
    end else begin
      exp_araddr = addr & 16'hFFFC;
    end
    e.wr    = wr;
    e.rdata = wr ? 32'h0 : exp_rd;
    e.resp  = exp_resp;
    sb.push_back(e);
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp_rd,
                        input logic [1:0] exp_resp);
    @(posedge clk); #1;
    aw_len = 0; w_len = 0; ar_len = 0;
    set_cmd(wr, addr, wd, ws, exp_rd, exp_resp);
    wait_accept();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] hs_vec();
    return {26'h0, awvalid, wvalid, bready, arvalid, rready, rsp_valid};
  endfunction

  initial begin
    int b0;
    int aw_tab[3] = '{2, 0, 1};
    int w_tab[3]  = '{0, 2, 1};
    logic [1:0] br_tab[3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] d;

    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    check("rst_valids", hs_vec(), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_prot", {26'h0, awprot, arprot}, 32'd0);
    #1 areset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);

    // Minimum-latency write
    b0 = b_count;
    do_cmd(1'b1, 16'h0004, 32'h0000_0001, 4'hF, 32'h0, 2'b00);
    wait_idle();
    check("wr_lat", rsp_rise - acc_cyc, 32'd3);
    check("wr_aw_len", aw_len, 32'd1);
    check("wr_w_len", w_len, 32'd1);
    check("wr_b_count", b_count - b0, 32'd1);

    // Minimum-latency read
    s_rdata = 32'hA5A5_0001; s_rresp = 2'b00;
    do_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00);
    wait_idle();
    check("rd_lat", rsp_rise - acc_cyc, 32'd3);

    // Read with delayed AR and R
    ar_dly = 3; r_dly = 2; s_rdata = 32'h0000_1234; s_rresp = 2'b00;
    do_cmd(1'b0, 16'h0080, 32'h0, 4'h0, 32'h0000_1234, 2'b00);
    wait_idle();
    check("rd_ar_len", ar_len, 32'd4);
    ar_dly = 0; r_dly = 0;

    // AW/W completion orders: W first, AW first, simultaneous
    for (int i = 0; i < 3; i++) begin
      aw_dly = aw_tab[i]; w_dly = w_tab[i]; b_dly = i; s_bresp = br_tab[i];
      d = $urandom;
      b0 = b_count;
      do_cmd(1'b1, 16'h0100 + 16'(i * 4), d, 4'(i + 3), 32'h0, br_tab[i]);
      wait_idle();
      check("ord_aw_len", aw_len, 32'(aw_tab[i] + 1));
      check("ord_w_len", w_len, 32'(w_tab[i] + 1));
      check("ord_b_count", b_count - b0, 32'd1);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; s_bresp = 2'b00;

    // SLVERR read held by rsp_ready low for 5 cycles
    s_rdata = 32'hCAFE_0000; s_rresp = 2'b10;
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 32'hCAFE_0000, 2'b10);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hCAFE_0000);
      check("hold_rsp_resp", {30'h0, rsp_resp}, 32'd2);
      check("hold_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    s_rresp = 2'b00;

    // Back-to-back with cmd_valid held; unaligned address is word-aligned
    @(posedge clk); #1;
    set_cmd(1'b1, 16'h0007, 32'h1111_2222, 4'hF, 32'h0, 2'b00);
    wait_accept();
    @(posedge clk); #1;
    s_rdata = 32'h0BAD_F00D;
    set_cmd(1'b0, 16'h0008, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00);
    wait_accept();
    check("b2b_gap", acc_cyc - hs_cyc, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle();

    // Reset while waiting in RD_DATA
    r_dly = 20; s_rdata = 32'h7777_7777;
    do_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 32'h7777_7777, 2'b00);
    begin
      int n = 0;
      while (!rready && n < 50) begin @(negedge clk); n++; end
      check("rd_data_reached", {31'h0, rready}, 32'd1);
    end
    #1 areset = 1'b1;
    @(negedge clk);
    sb.delete();
    check("midrst_valids", hs_vec(), 32'd0);
    check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    #1 areset = 1'b0;
    r_dly = 0;
    @(negedge clk);
    check("midrst_cmd_ready_after", {31'h0, cmd_ready}, 32'd1);
    check("midrst_idle_valids", hs_vec(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
